// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single integer register-file write port between
// the in-order pipeline writeback stream and queued multiply/divide results.
// MDU results wait in a small FIFO and drain into idle port cycles. The pipeline
// is stalled only when the FIFO head must go first: FIFO full, starvation limit
// reached, or a write-after-write hazard against a queued destination.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   pipe_valid/pipe_rd/pipe_data     pipeline writeback result
//   pipe_ready                       pipeline result accepted this cycle
//   mdu_valid/mdu_rd/mdu_data        MDU result
//   mdu_ready                        FIFO can accept an MDU result this cycle
//   wr_en/wr_addr/wr_data            registered register-file write port
//   busy                             FIFO non-empty (registered)
module wb_port_arbiter #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned REGW         = 5,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pipe_valid,
  input  logic [REGW-1:0] pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  output logic            pipe_ready,
  input  logic            mdu_valid,
  input  logic [REGW-1:0] mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            mdu_ready,
  output logic            wr_en,
  output logic [REGW-1:0] wr_addr,
  output logic [XLEN-1:0] wr_data,
  output logic            busy
);

  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam int unsigned STW  = $clog2(STARVE_LIMIT + 1);

  // FIFO storage and control state
  logic [REGW-1:0] fifoRd   [DEPTH];
  logic [XLEN-1:0] fifoData [DEPTH];
  logic [PTRW-1:0] rdPtr, wrPtr;
  logic [CNTW-1:0] count, countNext;
  logic [STW-1:0]  starve;

  logic            fifoFull, fifoNonEmpty, starveHit, waw, forceHead;
  logic            grantFifo, grantPipe, push;
  logic [PTRW-1:0] slotOffs;

  assign fifoFull     = (count == CNTW'(DEPTH));
  assign fifoNonEmpty = (count != '0);
  assign starveHit    = (starve == STW'(STARVE_LIMIT));

  // WAW: a live FIFO slot targets the same nonzero register as the pipeline.
  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    waw      = 1'b0;
    slotOffs = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slotOffs = PTRW'(i) - rdPtr;
      if ((CNTW'(slotOffs) < count) && (fifoRd[i] == pipe_rd)) begin
        waw = 1'b1;
      end
    end
    waw = waw & pipe_valid & (pipe_rd != '0);
  end

  assign forceHead  = fifoFull | starveHit | waw;
  assign grantFifo  = !reset && fifoNonEmpty && (forceHead || !pipe_valid);
  assign pipe_ready = !reset && !grantFifo;
  assign grantPipe  = pipe_valid && pipe_ready;
  assign mdu_ready  = !reset && !fifoFull;
  assign push       = mdu_valid && mdu_ready;

  always_comb begin
    countNext = count;
    if (push && !grantFifo) countNext = count + CNTW'(1);
    if (!push && grantFifo) countNext = count - CNTW'(1);
  end

  // FIFO control, starvation counter and busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr  <= '0;
      wrPtr  <= '0;
      count  <= '0;
      starve <= '0;
      busy   <= 1'b0;
    end else begin
      if (push)      wrPtr <= wrPtr + PTRW'(1);
      if (grantFifo) rdPtr <= rdPtr + PTRW'(1);
      count <= countNext;
      busy  <= (countNext != '0);
      // Clears on a head pop or when empty; otherwise the head was bypassed
      if (grantFifo || !fifoNonEmpty) begin
        starve <= '0;
      end else if (!starveHit) begin
        starve <= starve + STW'(1);
      end
    end
  end

  // FIFO payload storage; contents are don't-care until counted live
  always_ff @(posedge clk) begin
    if (push) begin
      fifoRd[wrPtr]   <= mdu_rd;
      fifoData[wrPtr] <= mdu_data;
    end
  end

  // Registered write port; address/data hold when nothing is granted
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (grantFifo) begin
      wr_en   <= (fifoRd[rdPtr] != '0);
      wr_addr <= fifoRd[rdPtr];
      wr_data <= fifoData[rdPtr];
    end else if (grantPipe) begin
      wr_en   <= (pipe_rd != '0);
      wr_addr <= pipe_rd;
      wr_data <= pipe_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a queue-based model of the arbitration rules.
module tb_wb_port_arbiter;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned REGW  = 5;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            pipe_valid = 1'b0;
  logic [REGW-1:0] pipe_rd = '0;
  logic [XLEN-1:0] pipe_data = '0;
  logic            pipe_ready;
  logic            mdu_valid = 1'b0;
  logic [REGW-1:0] mdu_rd = '0;
  logic [XLEN-1:0] mdu_data = '0;
  logic            mdu_ready;
  logic            wr_en;
  logic [REGW-1:0] wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            busy;

  wb_port_arbiter #(.XLEN(XLEN), .REGW(REGW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_ready(pipe_ready),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] data;
  } entry_t;

  // Reference model state
  entry_t          q[$];
  int              starveM = 0;
  logic            expWrEn = 1'b0;
  logic [REGW-1:0] expWrAddr = '0;
  logic [XLEN-1:0] expWrData = '0;
  logic            expBusy = 1'b0;
  logic [XLEN-1:0] regFile [32];

  int nChecks = 0;
  int nPassed = 0;

  task automatic checkEq(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    nChecks++;
    if (obs === exp) nPassed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // One clock cycle: apply inputs, check handshakes, advance model, check port
  task automatic cycle(input logic rst, input logic pv, input logic [REGW-1:0] prd,
                       input logic [XLEN-1:0] pd, input logic mv, input logic [REGW-1:0] mrd,
                       input logic [XLEN-1:0] md);
    logic   expPr, expMr, wawM, forceM, popM;
    entry_t e;
    reset = rst; pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    #1;
    if (rst) begin
      checkEq("pipe_ready_rst", XLEN'(pipe_ready), '0);
      checkEq("mdu_ready_rst", XLEN'(mdu_ready), '0);
      q.delete();
      starveM = 0;
      expWrEn = 1'b0; expWrAddr = '0; expWrData = '0;
    end else begin
      wawM = 1'b0;
      foreach (q[i]) if (pv && prd != 0 && q[i].rd == prd) wawM = 1'b1;
      forceM = (q.size() == DEPTH) || (starveM == LIMIT) || wawM;
      popM   = (q.size() > 0) && (forceM || !pv);
      expPr  = !popM;
      expMr  = (q.size() < DEPTH);
      checkEq("pipe_ready", XLEN'(pipe_ready), XLEN'(expPr));
      checkEq("mdu_ready", XLEN'(mdu_ready), XLEN'(expMr));
      if (popM) begin
        e = q.pop_front();
        expWrEn = (e.rd != 0); expWrAddr = e.rd; expWrData = e.data;
        starveM = 0;
      end else begin
        if (pv) begin
          expWrEn = (prd != 0); expWrAddr = prd; expWrData = pd;
        end else begin
          expWrEn = 1'b0;
        end
        starveM = (q.size() == 0) ? 0 : ((starveM < LIMIT) ? starveM + 1 : LIMIT);
      end
      if (mv && expMr) begin
        e.rd = mrd; e.data = md;
        q.push_back(e);
      end
    end
    expBusy = (q.size() != 0);
    @(posedge clk); #1;
    checkEq("wr_en", XLEN'(wr_en), XLEN'(expWrEn));
    checkEq("wr_addr", XLEN'(wr_addr), XLEN'(expWrAddr));
    checkEq("wr_data", wr_data, expWrData);
    checkEq("busy", XLEN'(busy), XLEN'(expBusy));
    if (wr_en === 1'b1) regFile[wr_addr] = wr_data;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    @(posedge clk); #1;
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);

    // Idle port: MDU result drains on its own
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 64'h1234);
    idle(); idle();

    // Starvation: one queued rd=7 against continuous pipeline writes
    cycle(1'b0, 1'b1, 5'd1, 64'h100, 1'b1, 5'd7, 64'h777);
    for (int i = 2; i <= 9; i++) cycle(1'b0, 1'b1, 5'(i), 64'(i * 16), 1'b0, '0, '0);
    idle();

    // WAW: queued 3<-0xA must land before pipeline 3<-0xB
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 64'hA);
    cycle(1'b0, 1'b1, 5'd3, 64'hB, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, 5'd3, 64'hB, 1'b0, '0, '0);
    idle();
    checkEq("x3_final", regFile[3], 64'hB);

    // Full FIFO while the pipeline keeps writing
    cycle(1'b0, 1'b1, 5'd10, 64'h10, 1'b1, 5'd20, 64'h20);
    cycle(1'b0, 1'b1, 5'd11, 64'h11, 1'b1, 5'd21, 64'h21);
    cycle(1'b0, 1'b1, 5'd12, 64'h12, 1'b1, 5'd22, 64'h22);
    cycle(1'b0, 1'b1, 5'd12, 64'h12, 1'b1, 5'd22, 64'h22);
    idle(); idle(); idle();

    // x0 from both sources
    cycle(1'b0, 1'b1, 5'd0, 64'hFF, 1'b1, 5'd0, 64'hEE);
    cycle(1'b0, 1'b1, 5'd0, 64'hFF, 1'b0, '0, '0);
    idle(); idle();

    // Reset with two queued entries
    cycle(1'b0, 1'b1, 5'd1, 64'h1, 1'b1, 5'd8, 64'h8);
    cycle(1'b0, 1'b1, 5'd2, 64'h2, 1'b1, 5'd9, 64'h9);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    idle(); idle();

    // Random traffic with a small register range to provoke WAW
    for (int n = 0; n < 3000; n++) begin
      logic            rst, pv, mv;
      logic [REGW-1:0] prd, mrd;
      rst = ($urandom_range(0, 199) == 0);
      pv  = ($urandom_range(0, 3) != 0);
      mv  = ($urandom_range(0, 2) == 0);
      prd = REGW'($urandom_range(0, 4));
      mrd = REGW'($urandom_range(0, 4));
      cycle(rst, pv, prd, {$urandom, $urandom}, mv, mrd, {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single integer register-file write port between the in-order pipeline writeback stream and the multi-cycle multiply/divide unit (MDU).
- MDU results are queued in a small FIFO and drained into idle port cycles. The pipeline is stalled only when a queued result must go first: buffer full, starvation, or write-after-write ordering.
- Sits after the writeback data select. Its registered outputs drive the register file write port directly.

Parameters:
XLEN, 64, data width of write port
REGW, 5, register index width
DEPTH, 2, MDU result FIFO entries (power of two, >=2)
STARVE_LIMIT, 4, max consecutive cycles a queued MDU result may be bypassed by pipeline writes

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
pipe_valid  in  1  pipeline writeback result present
pipe_rd  in  REGW  pipeline destination register
pipe_data  in  XLEN  pipeline writeback data
pipe_ready  out  1  pipeline result accepted this cycle (stall when low with pipe_valid)
mdu_valid  in  1  MDU result present
mdu_rd  in  REGW  MDU destination register
mdu_data  in  XLEN  MDU result
mdu_ready  out  1  FIFO can accept MDU result this cycle
wr_en  out  1  register file write enable (registered)
wr_addr  out  REGW  register file write index (registered)
wr_data  out  XLEN  register file write data (registered)
busy  out  1  FIFO non-empty (registered count != 0)

Behaviour:
- Reset:
  - wr_en=0, wr_addr=0, wr_data=0.
  - FIFO count=0, read/write pointers=0, starvation counter=0.
  - pipe_ready and mdu_ready are forced 0 while reset is high.
- MDU enqueue:
  - mdu_ready = (count < DEPTH), taken from registered count.
  - mdu_valid & mdu_ready pushes {mdu_rd, mdu_data} at the clock edge.
  - No bypass: a result enqueued in cycle N is granted no earlier than N+1.
- Conflict/force term (combinational, from registered FIFO state): force = (count==DEPTH) | (starve==STARVE_LIMIT) | waw.
- waw = pipe_valid & pipe_rd!=0 & pipe_rd equals rd of any valid FIFO entry. An older MDU write must land before a younger pipeline write to the same register.
- Grant each cycle:
  - count>0 & (force | !pipe_valid): grant FIFO head, pop it, pipe_ready=0.
  - Otherwise: pipe_ready=1; if pipe_valid, grant pipeline.
  - At most one grant per cycle.
- Write port: registered one cycle after grant.
  - wr_en = granted & granted_rd!=0; wr_addr/wr_data = granted rd/data.
  - With no grant, wr_en=0 and wr_addr/wr_data hold their previous values.
- x0: entries with rd=0 are consumed normally (pop/accept) but produce wr_en=0. rd=0 never creates a waw conflict.
- Simultaneous push and pop in one cycle:
  - Allowed when count<DEPTH; count unchanged.
  - When full, mdu_ready=0, so no push occurs.
- Pointer wrap: pointers wrap modulo DEPTH. FIFO order is strictly preserved.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle count>0 and the head is not granted.
  - Clears on a head pop or when the FIFO is empty.
- Reset mid-operation: queued MDU results are discarded. The pipeline/MDU controller is responsible for squashing in-flight ops.
- busy reflects registered count. It is used by hazard logic to block reads of pending MDU destinations.

Test Plan:
- Idle port:
  - Stimulus: mdu push rd=5 data=0x1234 in cycle 0, pipe_valid=0.
  - Response: grant in cycle 1; wr_en=1 wr_addr=5 wr_data=0x1234 in cycle 2; busy 1 in cycle 1, 0 in cycle 2.
- Pipeline priority plus starvation:
  - Stimulus: one MDU entry rd=7; pipe_valid=1 continuously with rd=1..9.
  - Response: pipeline writes for 4 cycles; 5th cycle pipe_ready=0 and rd=7 is written next; pipeline resumes the cycle after.
- WAW:
  - Stimulus: FIFO holds rd=3 data=0xA; pipe_valid rd=3 data=0xB.
  - Response: pipe_ready=0; write 3<-0xA first, then 3<-0xB on the following cycle; final x3=0xB.
- Full FIFO:
  - Stimulus: DEPTH=2; push two MDU results while pipe_valid=1.
  - Response: mdu_ready=0 at count=2; head forced out with pipe_ready=0; mdu_ready returns to 1 the cycle after the pop.
- x0 handling:
  - Stimulus: pipe rd=0 data=0xFF, then mdu rd=0.
  - Response: both accepted or popped; wr_en stays 0; no stall from waw.
- Reset mid-operation:
  - Stimulus: 2 entries queued, reset high 1 cycle.
  - Response: next cycle busy=0, wr_en=0, mdu_ready=1, wr_addr=0, wr_data=0; no stale writes follow.
